// File: rtl/video_scroll.sv
// video_scroll: PPU scroll/address registers v, t, fine X and write toggle w.
module video_scroll #(
    parameter logic [14:0] P_reset_vaddr = 15'h0000
) (
    input  logic        I_vid_clock,
    input  logic        I_reset,
    input  logic        I_clk_rise,
    input  logic [15:0] I_control,
    input  logic        I_render_enable,
    input  logic        I_reg_write,
    input  logic        I_reg_read,
    input  logic [2:0]  I_reg_addr,
    input  logic [7:0]  I_reg_data,
    output logic [14:0] O_vaddr,
    output logic [14:0] O_taddr,
    output logic [2:0]  O_fine_x,
    output logic        O_write_toggle
);
    logic [14:0] v, t, v_n, t_n;
    logic [2:0]  x, x_n;
    logic        w, w_n, incr32, incr32_n;
    logic        active, acc7, inc_h, inc_v, cp_h, cp_v;
    logic        unused_ctrl;

    assign unused_ctrl = ^{I_control[15], I_control[9:0]};

    always_comb begin
        active   = I_control[10] & I_render_enable;
        acc7     = (I_reg_write | I_reg_read) && I_reg_addr == 3'd7;
        inc_h    = (I_render_enable & I_control[11]) | (acc7 & active);
        inc_v    = (I_render_enable & I_control[12]) | (acc7 & active);
        cp_h     = I_render_enable & I_control[13];
        cp_v     = I_render_enable & I_control[14];
        t_n      = t;
        x_n      = x;
        w_n      = w;
        incr32_n = incr32;
        if (I_reg_write && I_reg_addr == 3'd0) begin
            t_n[11:10] = I_reg_data[1:0];
            incr32_n   = I_reg_data[2];
        end
        if (I_reg_read && I_reg_addr == 3'd2)
            w_n = 1'b0;
        if (I_reg_write && I_reg_addr == 3'd5) begin
            if (!w) begin
                t_n[4:0] = I_reg_data[7:3];
                x_n      = I_reg_data[2:0];
            end else begin
                t_n[14:12] = I_reg_data[2:0];
                t_n[9:5]   = I_reg_data[7:3];
            end
            w_n = ~w;
        end
        if (I_reg_write && I_reg_addr == 3'd6) begin
            if (!w)
                t_n[14:8] = {1'b0, I_reg_data[5:0]};
            else
                t_n[7:0] = I_reg_data;
            w_n = ~w;
        end
        v_n = (acc7 && !active) ? v + (incr32 ? 15'd32 : 15'd1) : v;
        if (inc_h)
            {v_n[10], v_n[4:0]} = (v_n[4:0] == 5'd31) ? {~v_n[10], 5'd0} : {v_n[10], v_n[4:0] + 5'd1};
        // Fine Y carries into coarse Y; row 29 is the last visible tile row and wraps to the next nametable.
        if (inc_v) begin
            if (v_n[14:12] != 3'd7)
                v_n[14:12] = v_n[14:12] + 3'd1;
            else begin
                v_n[14:12] = 3'd0;
                v_n[11]    = (v_n[9:5] == 5'd29) ? ~v_n[11] : v_n[11];
                v_n[9:5]   = (v_n[9:5] == 5'd29 || v_n[9:5] == 5'd31) ? 5'd0 : v_n[9:5] + 5'd1;
            end
        end
        if (cp_h)
            {v_n[10], v_n[4:0]} = {t[10], t[4:0]};
        if (cp_v)
            {v_n[14:11], v_n[9:5]} = {t[14:11], t[9:5]};
        if (I_reg_write && I_reg_addr == 3'd6 && w)
            v_n = {t[14:8], I_reg_data};
    end

    always_ff @(posedge I_vid_clock or posedge I_reset) begin
        if (I_reset) begin
            v      <= P_reset_vaddr;
            t      <= P_reset_vaddr;
            x      <= 3'd0;
            w      <= 1'b0;
            incr32 <= 1'b0;
        end else if (I_clk_rise) begin
            v      <= v_n;
            t      <= t_n;
            x      <= x_n;
            w      <= w_n;
            incr32 <= incr32_n;
        end
    end

    assign O_vaddr        = v;
    assign O_taddr        = t;
    assign O_fine_x       = x;
    assign O_write_toggle = w;
endmodule
